imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 153 +++++++++++++++
 tb/tb_imem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: shares one single-port memory between
// instruction fetch (reads) and a program loader (writes), with a boot-load
// mode that locks fetch out and a starvation limit that protects fetch.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef RESET_PC_VALUE
`define RESET_PC_VALUE 32'h0000_1000
`endif

module imem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_i,
  input  logic [`CPU_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [`CPU_WIDTH-1:0] if_rdata_o,
  output logic                  if_err_o,
  input  logic                  ld_req_i,
  input  logic [`CPU_WIDTH-1:0] ld_addr_i,
  input  logic [`CPU_WIDTH-1:0] ld_wdata_i,
  output logic                  ld_gnt_o,
  input  logic                  ld_burst_i,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [`CPU_WIDTH-1:0] mem_wdata_o,
  input  logic [`CPU_WIDTH-1:0] mem_rdata_i,
  output logic                  stall_o
);

  localparam logic [`CPU_WIDTH-1:0] RESET_PC = `RESET_PC_VALUE;
  localparam logic [`CPU_WIDTH-1:0] NOP      = `CPU_WIDTH'(32'h0000_0013);
  localparam logic [3:0]            WAIT_MAX = 4'(MAX_WAIT);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       rvalid_q, rvalid_d;
  logic       err_q, err_d;

  // Offsets from the reset PC; addresses below it wrap to huge values and
  // therefore fail the range test without a separate lower-bound compare.
  logic [`CPU_WIDTH-1:0] if_off, ld_off;
  logic                  if_ok, ld_ok;
  logic [ADDR_W-1:0]     if_idx, ld_idx;

  assign if_off = if_addr_i - RESET_PC;
  assign ld_off = ld_addr_i - RESET_PC;
  assign if_ok  = (if_addr_i[1:0] == 2'b00) && ((if_off >> (ADDR_W + 2)) == '0);
  assign ld_ok  = (ld_addr_i[1:0] == 2'b00) && ((ld_off >> (ADDR_W + 2)) == '0);
  assign if_idx = if_off[ADDR_W+1:2];
  assign ld_idx = ld_off[ADDR_W+1:2];

  // State, starvation counter and read-response pipeline; reset is synchronous.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q  <= RUN;
      wait_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // Mode transitions and grant decision; fetch is locked out whenever a
  // boot-load burst is requested or in progress.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    if_gnt_o = 1'b0;
    ld_gnt_o = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ld_burst_i) state_d = HOLD;
        if (if_req_i && !ld_burst_i && (!ld_req_i || (wait_q == WAIT_MAX))) begin
          if_gnt_o = 1'b1;
        end else begin
          ld_gnt_o = ld_req_i;
        end
      end
      HOLD: begin
        ld_gnt_o = ld_req_i;
        if (!ld_burst_i && !ld_req_i) state_d = RUN;
      end
    endcase
    if (!rst_n) begin
      if_gnt_o = 1'b0;
      ld_gnt_o = 1'b0;
    end
  end

  // Starvation counter: counts stalled fetch cycles in RUN, saturating.
  always_comb begin
    wait_d = wait_q;
    if ((state_q == HOLD) || !if_req_i || if_gnt_o) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 4'd1;
    end
  end

  // Memory port drive; invalid addresses are granted but never reach memory.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (ld_gnt_o && ld_ok) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = ld_idx;
      mem_wdata_o = ld_wdata_i;
    end else if (if_gnt_o && if_ok) begin
      mem_en_o   = 1'b1;
      mem_addr_o = if_idx;
    end
  end

  // One-cycle response pulse per fetch grant, flagged if the address was bad.
  always_comb begin
    rvalid_d = if_gnt_o;
    err_d    = if_gnt_o && !if_ok;
  end

  // Response data: memory word, or a NOP for a rejected fetch; zero otherwise
  // and throughout reset so a grant just before reset never surfaces.
  always_comb begin
    if_rdata_o = '0;
    if (rst_n && rvalid_q) if_rdata_o = err_q ? NOP : mem_rdata_i;
  end

  assign if_rvalid_o = rvalid_q & rst_n;
  assign if_err_o    = err_q & rst_n;
  assign stall_o     = if_req_i & ~if_gnt_o;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus randomized
// traffic, checked against a cycle-level reference model and a response queue.
`timescale 1ns/1ps

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef RESET_PC_VALUE
`define RESET_PC_VALUE 32'h0000_1000
`endif

module tb_imem_arbiter;

  localparam int          ADDR_W   = 10;
  localparam int          MAX_WAIT = 4;
  localparam int          DEPTH    = 1 << ADDR_W;
  localparam logic [31:0] BASE     = `RESET_PC_VALUE;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o, if_err_o;
  logic [31:0] if_rdata_o;
  logic        ld_req_i = 1'b0;
  logic [31:0] ld_addr_i = '0;
  logic [31:0] ld_wdata_i = '0;
  logic        ld_gnt_o;
  logic        ld_burst_i = 1'b0;
  logic        mem_en_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        stall_o;

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_wdata_i(ld_wdata_i),
    .ld_gnt_o(ld_gnt_o), .ld_burst_i(ld_burst_i),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory device attached to the DUT, and the reference image of it.
  logic [31:0] dev_mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) dev_mem[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i <= dev_mem[mem_addr_o];
    end
  end

  function automatic bit addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] == 2'b00) && ((off / 4) < 32'(DEPTH));
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off / 4) % DEPTH;
  endfunction

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } resp_t;

  resp_t sb[$];
  int    cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model: boot-mode flag and count of stalled fetch cycles.
  bit boot_mode = 1'b0;
  int starve    = 0;
  bit g_if = 1'b0;
  bit g_ld = 1'b0;

  always @(negedge clk) begin
    bit          e_if, e_ld, e_en, e_we;
    logic [31:0] e_addr, e_wd;
    resp_t       r;
    e_if = 0; e_ld = 0; e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
    if (rst_n) begin
      // Fetch wins only outside boot mode, and only if unopposed or starved.
      e_if = if_req_i && !boot_mode && !ld_burst_i && (!ld_req_i || starve == MAX_WAIT);
      e_ld = ld_req_i && !e_if;
      if (e_ld && addr_ok(ld_addr_i)) begin
        e_en = 1; e_we = 1; e_addr = widx(ld_addr_i); e_wd = ld_wdata_i;
      end
      if (e_if && addr_ok(if_addr_i)) begin
        e_en = 1; e_addr = widx(if_addr_i);
      end
    end
    check("if_gnt", if_gnt_o, e_if);
    check("ld_gnt", ld_gnt_o, e_ld);
    check("mem_en", mem_en_o, e_en);
    check("stall", stall_o, if_req_i && !e_if);
    if (e_en || !(e_if || e_ld)) begin
      check("mem_we", mem_we_o, e_we);
      check("mem_addr", mem_addr_o, e_addr);
      check("mem_wdata", mem_wdata_o, e_wd);
    end
    g_if = if_gnt_o;
    g_ld = ld_gnt_o;
    if (!rst_n) begin
      boot_mode = 0;
      starve    = 0;
    end else begin
      if (e_if) begin
        r.data = addr_ok(if_addr_i) ? ref_mem[widx(if_addr_i)] : NOP;
        r.err  = !addr_ok(if_addr_i);
        r.cyc  = cyc;
        sb.push_back(r);
      end
      if (e_ld && addr_ok(ld_addr_i)) ref_mem[widx(ld_addr_i)] = ld_wdata_i;
      if (boot_mode || !if_req_i || e_if) starve = 0;
      else if (starve < MAX_WAIT)         starve = starve + 1;
      boot_mode = boot_mode ? (ld_burst_i || ld_req_i) : ld_burst_i;
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents a fetch.
  always @(negedge clk) begin
    resp_t r;
    if (!rst_n) begin
      check("rst_rvalid", if_rvalid_o, 0);
      check("rst_err", if_err_o, 0);
      check("rst_rdata", if_rdata_o, 0);
      sb.delete();
    end else if (if_rvalid_o) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rvalid_unexpected: got rvalid=1 expected none (t=%0t)", $time);
      end else begin
        r = sb.pop_front();
        check("rvalid_latency", 32'(cyc), 32'(r.cyc + 1));
        check("rdata", if_rdata_o, r.data);
        check("err", if_err_o, r.err);
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_cmp++; n_err++;
      $display("FAIL rvalid_missing: got rvalid=0 expected 1 (t=%0t)", $time);
      void'(sb.pop_front());
    end
  end

  // Advance one cycle; inputs change just after the edge, held until granted.
  task automatic tick();
    @(posedge clk);
    #1;
    if (g_if) if_req_i = 1'b0;
    if (g_ld) ld_req_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(9, 0);
    if (k < 7)  return BASE + 32'(4 * $urandom_range(31, 0));
    if (k == 7) return BASE + 32'(4 * $urandom_range(31, 0)) + 32'($urandom_range(3, 1));
    if (k == 8) return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(255, 0));
    return BASE - 32'(4 * $urandom_range(16, 1));
  endfunction

  initial begin
    int burst_left;
    burst_left = 0;
    for (int i = 0; i < DEPTH; i++) begin
      dev_mem[i] = $urandom();
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[2] = 32'h00A0_0093;
    ref_mem[2] = 32'h00A0_0093;

    // Reset state.
    if_req_i = 1'b1;
    ld_req_i = 1'b1;
    @(negedge clk);
    check("reset_if_gnt", if_gnt_o, 0);
    check("reset_ld_gnt", ld_gnt_o, 0);
    check("reset_mem_en", mem_en_o, 0);
    tick();
    if_req_i = 1'b0;
    ld_req_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Aligned in-range fetch.
    if_req_i  = 1'b1;
    if_addr_i = BASE + 32'd8;
    @(negedge clk);
    check("fetch_gnt", if_gnt_o, 1);
    check("fetch_mem_addr", mem_addr_o, 2);
    tick();
    @(negedge clk);
    check("fetch_rvalid", if_rvalid_o, 1);
    check("fetch_rdata", if_rdata_o, 32'h00A0_0093);
    tick();

    // Both requests held: loader wins until fetch has waited MAX_WAIT cycles.
    if_req_i   = 1'b1;
    if_addr_i  = BASE + 32'd12;
    ld_req_i   = 1'b1;
    ld_addr_i  = BASE + 32'd64;
    ld_wdata_i = 32'hCAFE_0001;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("starve_if_gnt_%0d", k), if_gnt_o, (k == MAX_WAIT) ? 1 : 0);
      check($sformatf("starve_ld_gnt_%0d", k), ld_gnt_o, (k == MAX_WAIT) ? 0 : 1);
      tick();
      ld_req_i   = 1'b1;
      ld_wdata_i = ld_wdata_i + 32'd1;
    end
    ld_req_i = 1'b0;
    tick();

    // Boot-load burst blocks a pending fetch until the mode is left.
    if_req_i   = 1'b1;
    if_addr_i  = BASE + 32'd16;
    ld_burst_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("burst_if_gnt_%0d", k), if_gnt_o, 0);
      check($sformatf("burst_stall_%0d", k), stall_o, 1);
      tick();
    end
    ld_burst_i = 1'b0;
    @(negedge clk);
    check("burst_exit_hold", if_gnt_o, 0);
    tick();
    @(negedge clk);
    check("burst_exit_run", if_gnt_o, 1);
    tick();

    // Misaligned then out-of-range fetch, back to back.
    if_req_i  = 1'b1;
    if_addr_i = BASE + 32'd2;
    @(negedge clk);
    check("misalign_gnt", if_gnt_o, 1);
    check("misalign_mem_en", mem_en_o, 0);
    tick();
    if_req_i  = 1'b1;
    if_addr_i = BASE + 32'd4096;
    @(negedge clk);
    check("misalign_err", if_err_o, 1);
    check("misalign_rdata", if_rdata_o, NOP);
    check("range_mem_en", mem_en_o, 0);
    tick();
    @(negedge clk);
    check("range_rvalid", if_rvalid_o, 1);
    check("range_err", if_err_o, 1);
    check("range_rdata", if_rdata_o, NOP);
    tick();

    // Reset right after a fetch grant swallows its response.
    if_req_i  = 1'b1;
    if_addr_i = BASE + 32'd20;
    @(negedge clk);
    check("prerst_gnt", if_gnt_o, 1);
    tick();
    rst_n      = 1'b0;
    ld_req_i   = 1'b1;
    ld_addr_i  = BASE + 32'd24;
    @(negedge clk);
    check("midrst_rvalid", if_rvalid_o, 0);
    check("midrst_rdata", if_rdata_o, 0);
    check("midrst_ld_gnt", ld_gnt_o, 0);
    check("midrst_mem_en", mem_en_o, 0);
    check("midrst_stall", stall_o, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      if (!if_req_i && $urandom_range(2, 0) != 0) begin
        if_req_i  = 1'b1;
        if_addr_i = rand_addr();
      end
      if (!ld_req_i && $urandom_range(3, 0) < (ld_burst_i ? 3 : 1)) begin
        ld_req_i   = 1'b1;
        ld_addr_i  = rand_addr();
        ld_wdata_i = $urandom();
      end
      if (burst_left > 0) burst_left--;
      else if ($urandom_range(60, 0) == 0) burst_left = $urandom_range(8, 2);
      ld_burst_i = (burst_left > 0);
      rst_n      = ($urandom_range(250, 0) != 0);
      tick();
    end

    // Drain outstanding responses.
    rst_n      = 1'b1;
    if_req_i   = 1'b0;
    ld_req_i   = 1'b0;
    ld_burst_i = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
